// File: rtl/fb_axi_pkg.sv
// rtl/fb_axi_pkg.sv - shared AXI3 codes, burst limits and FSM state type for the framebuffer reader
package fb_axi_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
  localparam int         MAX_BEATS      = 16;
  localparam int         PAGE_WORDS     = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

  // Beats for the next burst: capped by the burst limit, the row remainder and the 4 KB page.
  function automatic logic [4:0] burst_beats(input logic [8:0] words_left, input logic [9:0] addr_word);
    logic [10:0] page_left;
    logic [10:0] b;
    page_left = 11'(PAGE_WORDS) - {1'b0, addr_word};
    b = 11'(MAX_BEATS);
    if ({2'b00, words_left} < b) b = {2'b00, words_left};
    if (page_left < b) b = page_left;
    return 5'(b);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/axi_framebuffer_reader_axi3.sv
// rtl/axi_framebuffer_reader_axi3.sv - reads a framebuffer rectangle over AXI3 and streams it out as 8-bit pixels
module axi_framebuffer_reader_axi3
  import fb_axi_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int STRIDE     = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] framebuffer_baseaddr,
  input  logic [10:0] x0,
  input  logic [10:0] y0,
  input  logic [10:0] width,
  input  logic [10:0] height,
  output logic        busy,
  output logic        done,
  output logic        rresp_err,
  output logic [7:0]  m_pixel_data,
  output logic        m_pixel_valid,
  input  logic        m_pixel_ready,
  output logic        m_pixel_eol,
  output logic        m_pixel_eof,
  output logic [31:0] M00_AXI_araddr,
  output logic [3:0]  M00_AXI_arlen,
  output logic [2:0]  M00_AXI_arsize,
  output logic [1:0]  M00_AXI_arburst,
  output logic [3:0]  M00_AXI_arcache,
  output logic [1:0]  M00_AXI_arlock,
  output logic [2:0]  M00_AXI_arprot,
  output logic [3:0]  M00_AXI_arqos,
  output logic        M00_AXI_aruser,
  output logic        M00_AXI_arvalid,
  input  logic        M00_AXI_arready,
  input  logic [31:0] M00_AXI_rdata,
  input  logic [1:0]  M00_AXI_rresp,
  input  logic        M00_AXI_rlast,
  input  logic        M00_AXI_rvalid,
  output logic        M00_AXI_rready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state, state_next;
  logic [31:0]     cur_addr, row_addr, start_addr;
  logic [8:0]      words_left, row_words, out_col;
  logic [10:0]     rows_left, rows_total, out_row;
  logic            last_burst;
  logic [4:0]      beats;
  logic [CW-1:0]   fifo_count, fifo_free;
  logic            space_ok, accept, empty_req, end_of_row;
  logic            ar_fire, r_fire, pix_fire, last_pix_fire;
  logic            fifo_empty, fifo_pop, fifo_full_unused;
  logic [31:0]     fifo_data, pix_word;
  logic [1:0]      pix_idx;
  logic            unused_bits;

  assign M00_AXI_arsize  = AXI_SIZE_4B;
  assign M00_AXI_arburst = AXI_BURST_INCR;
  assign M00_AXI_arcache = AXI_CACHE_BUF;
  assign M00_AXI_arlock  = 2'b00;
  assign M00_AXI_arprot  = 3'b000;
  assign M00_AXI_arqos   = 4'b0000;
  assign M00_AXI_aruser  = 1'b0;
  assign unused_bits     = ^{x0[1:0], width[1:0]};

  assign start_addr    = framebuffer_baseaddr + 32'(y0) * 32'(STRIDE) + {21'd0, x0[10:2], 2'b00};
  assign beats         = burst_beats(words_left, cur_addr[11:2]);
  assign fifo_free     = CW'(FIFO_DEPTH) - fifo_count;
  assign space_ok      = (fifo_free >= CW'(beats));
  assign accept        = (state == ST_IDLE) && start;
  assign empty_req     = (width[10:2] == 9'd0) || (height == 11'd0);
  assign end_of_row    = (words_left == {4'd0, beats});
  assign ar_fire       = M00_AXI_arvalid && M00_AXI_arready;
  assign r_fire        = M00_AXI_rvalid && M00_AXI_rready;
  assign pix_fire      = m_pixel_valid && m_pixel_ready;
  assign last_pix_fire = pix_fire && m_pixel_eof;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (accept && !empty_req) state_next = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (space_ok) state_next = ST_ADDR;
      ST_ADDR:       if (ar_fire) state_next = ST_DATA;
      ST_DATA:       if (r_fire && M00_AXI_rlast) state_next = last_burst ? ST_DRAIN : ST_WAIT_SPACE;
      ST_DRAIN:      if (last_pix_fire) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != ST_IDLE);
    M00_AXI_arvalid = (state == ST_ADDR);
    M00_AXI_rready  = (state == ST_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done           <= 1'b0;
      rresp_err      <= 1'b0;
      M00_AXI_araddr <= '0;
      M00_AXI_arlen  <= '0;
      cur_addr       <= '0;
      row_addr       <= '0;
      words_left     <= '0;
      row_words      <= '0;
      rows_left      <= '0;
      rows_total     <= '0;
      last_burst     <= 1'b0;
    end else begin
      done <= (accept && empty_req) || ((state == ST_DRAIN) && last_pix_fire);
      if (accept) rresp_err <= 1'b0;
      else if (r_fire && (M00_AXI_rresp != 2'b00)) rresp_err <= 1'b1;
      if (accept) begin
        cur_addr   <= start_addr;
        row_addr   <= start_addr;
        words_left <= width[10:2];
        row_words  <= width[10:2];
        rows_left  <= height;
        rows_total <= height;
        last_burst <= 1'b0;
      end
      if ((state == ST_WAIT_SPACE) && space_ok) begin
        M00_AXI_araddr <= cur_addr;
        M00_AXI_arlen  <= 4'(beats - 5'd1);
      end
      // Advance the burst cursor once the address is accepted; araddr stays frozen meanwhile.
      if (ar_fire) begin
        if (end_of_row) begin
          if (rows_left == 11'd1) begin
            last_burst <= 1'b1;
          end else begin
            rows_left  <= rows_left - 11'd1;
            row_addr   <= row_addr + 32'(STRIDE);
            cur_addr   <= row_addr + 32'(STRIDE);
            words_left <= row_words;
          end
        end else begin
          cur_addr   <= cur_addr + {25'd0, beats, 2'b00};
          words_left <= words_left - {4'd0, beats};
        end
      end
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_fire),
    .push_data (M00_AXI_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full_unused),
    .count     (fifo_count)
  );

  // Unpacker: refills on the cycle its last byte leaves, so a ready sink sees no bubbles.
  assign fifo_pop     = !fifo_empty && (!m_pixel_valid || (pix_fire && (pix_idx == 2'd3)));
  assign m_pixel_data = pix_word[{pix_idx, 3'b000} +: 8];
  assign m_pixel_eol  = m_pixel_valid && (pix_idx == 2'd3) && (out_col == row_words - 9'd1);
  assign m_pixel_eof  = m_pixel_eol && (out_row == rows_total - 11'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_word      <= '0;
      pix_idx       <= '0;
      m_pixel_valid <= 1'b0;
      out_col       <= '0;
      out_row       <= '0;
    end else begin
      if (accept) begin
        out_col <= '0;
        out_row <= '0;
      end else if (pix_fire && (pix_idx == 2'd3)) begin
        if (m_pixel_eol) begin
          out_col <= '0;
          out_row <= out_row + 11'd1;
        end else begin
          out_col <= out_col + 9'd1;
        end
      end
      if (pix_fire) pix_idx <= pix_idx + 2'd1;
      if (fifo_pop) begin
        pix_word      <= fifo_data;
        pix_idx       <= 2'd0;
        m_pixel_valid <= 1'b1;
      end else if (pix_fire && (pix_idx == 2'd3)) begin
        m_pixel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_framebuffer_reader_axi3.sv
// tb/tb_axi_framebuffer_reader_axi3.sv - scoreboard bench: AXI3 slave model, AR and pixel queues checked by a monitor
module tb_axi_framebuffer_reader_axi3;

  localparam int FIFO_DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [10:0] x0 = '0, y0 = '0, width = '0, height = '0;
  logic        busy, done, rresp_err;
  logic [7:0]  m_pixel_data;
  logic        m_pixel_valid, m_pixel_eol, m_pixel_eof;
  logic        m_pixel_ready = 1'b1;
  logic [31:0] araddr;
  logic [3:0]  arlen, arcache, arqos;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        aruser, arvalid, rready;
  logic        arready = 1'b1;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0, rvalid = 1'b0;

  axi_framebuffer_reader_axi3 #(.FIFO_DEPTH(FIFO_DEPTH), .STRIDE(800)) dut (
    .clk(clk), .reset(reset), .start(start), .framebuffer_baseaddr(base),
    .x0(x0), .y0(y0), .width(width), .height(height),
    .busy(busy), .done(done), .rresp_err(rresp_err),
    .m_pixel_data(m_pixel_data), .m_pixel_valid(m_pixel_valid), .m_pixel_ready(m_pixel_ready),
    .m_pixel_eol(m_pixel_eol), .m_pixel_eof(m_pixel_eof),
    .M00_AXI_araddr(araddr), .M00_AXI_arlen(arlen), .M00_AXI_arsize(arsize),
    .M00_AXI_arburst(arburst), .M00_AXI_arcache(arcache), .M00_AXI_arlock(arlock),
    .M00_AXI_arprot(arprot), .M00_AXI_arqos(arqos), .M00_AXI_aruser(aruser),
    .M00_AXI_arvalid(arvalid), .M00_AXI_arready(arready),
    .M00_AXI_rdata(rdata), .M00_AXI_rresp(rresp), .M00_AXI_rlast(rlast),
    .M00_AXI_rvalid(rvalid), .M00_AXI_rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [3:0] len; } ar_t;
  typedef struct { logic [7:0] d; logic eol; logic eof; } pix_t;
  ar_t  exp_ar[$];
  pix_t exp_pix[$];

  int errors = 0, checks = 0;
  int ar_count = 0, words_in = 0, pix_out = 0, beat_no = 0, err_beat = -1, cyc = 0;
  bit stall = 0, toggle = 0, ar_slow = 0, empty_mode = 0, overflow = 0;
  bit ar_fire_n = 0, r_fire_n = 0, eof_prev = 0, ar_hold = 0, pix_hold = 0;
  logic [31:0] ar_addr_n, held_addr;
  logic [3:0]  ar_len_n, held_len;
  logic [9:0]  held_pix;

  function automatic logic [7:0] pix_at(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [3:0] l);
    ar_t e;
    e.addr = a; e.len = l;
    exp_ar.push_back(e);
  endtask

  task automatic start_rect(input logic [31:0] b, input int xx, input int yy, input int w, input int h);
    pix_t e;
    logic [31:0] a;
    int wpr = w / 4;
    int xa = (xx / 4) * 4;
    for (int r = 0; r < h; r++)
      for (int i = 0; i < wpr * 4; i++) begin
        a = b + 32'((yy + r) * 800 + xa + i);
        e.d = pix_at(a);
        e.eol = (i == wpr * 4 - 1);
        e.eof = e.eol && (r == h - 1);
        exp_pix.push_back(e);
      end
    @(posedge clk); #1;
    base = b; x0 = 11'(xx); y0 = 11'(yy); width = 11'(w); height = 11'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = 32'hDEAD_BEEF; x0 = 11'h7FF; y0 = 11'h7FF; width = 11'h7FF; height = 11'h7FF;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_pix_left"}, 64'(exp_pix.size()), 64'd0);
    check({name, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
  endtask

  // Sink-ready and arready pacing
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    m_pixel_ready = stall ? 1'b0 : (toggle ? ((cyc % 3) != 0) : 1'b1);
    arready = ar_slow ? ((cyc % 4) == 3) : 1'b1;
  end

  // AXI3 read slave: one burst at a time, word at byte address a holds pix_at(a..a+3)
  initial begin
    logic [31:0] s_addr;
    int s_left;
    s_addr = '0; s_left = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        s_left = 0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
        if (r_fire_n) begin s_addr += 4; s_left--; beat_no++; end
        if (ar_fire_n) begin s_addr = ar_addr_n; s_left = int'(ar_len_n) + 1; end
        if (s_left > 0) begin
          rvalid = 1'b1;
          rdata = {pix_at(s_addr + 3), pix_at(s_addr + 2), pix_at(s_addr + 1), pix_at(s_addr)};
          rlast = (s_left == 1);
          rresp = (beat_no == err_beat) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
      end
    end
  end

  // Monitor: samples on the falling edge the handshakes that complete at the next rising edge
  initial forever begin
    pix_t e;
    ar_t  a;
    bit   pf;
    @(negedge clk);
    ar_fire_n = arvalid && arready;
    r_fire_n  = rvalid && rready;
    ar_addr_n = araddr;
    ar_len_n  = arlen;
    if (!reset) begin
      if (ar_hold && arvalid) check("ar_stable", {araddr, arlen}, {held_addr, held_len});
      ar_hold = arvalid && !arready; held_addr = araddr; held_len = arlen;
      if (ar_fire_n) begin
        ar_count++;
        if (exp_ar.size() == 0) check("ar_unexpected", {araddr, arlen}, 64'h0);
        else begin
          a = exp_ar.pop_front();
          check("ar", {araddr, arlen}, {a.addr, a.len});
        end
      end
      if (pix_hold && m_pixel_valid) check("pix_stable", {m_pixel_data, m_pixel_eol, m_pixel_eof}, 64'(held_pix));
      pix_hold = m_pixel_valid && !m_pixel_ready;
      held_pix = {m_pixel_data, m_pixel_eol, m_pixel_eof};
      pf = m_pixel_valid && m_pixel_ready;
      if (pf) begin
        pix_out++;
        if (exp_pix.size() == 0) check("pix_unexpected", {m_pixel_data, m_pixel_eol, m_pixel_eof}, 64'h0);
        else begin
          e = exp_pix.pop_front();
          check("pixel", {m_pixel_data, m_pixel_eol, m_pixel_eof}, {e.d, e.eol, e.eof});
        end
      end
      if (!empty_mode && (done || eof_prev)) check("done_after_eof", 64'(done), 64'(eof_prev));
      eof_prev = pf && m_pixel_eof;
      if (r_fire_n) words_in++;
      if (words_in - pix_out / 4 > FIFO_DEPTH + 1) overflow = 1;
    end else begin
      ar_hold = 0; pix_hold = 0; eof_prev = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rresp_err", 64'(rresp_err), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_pix_valid", 64'(m_pixel_valid), 64'd0);
    check("rst_eol_eof", {m_pixel_eol, m_pixel_eof}, 64'd0);
    check("rst_araddr_arlen", {araddr, arlen}, 64'd0);
    check("const_size_burst_cache", {arsize, arburst, arcache}, {3'b010, 2'b01, 4'b0011});
    check("const_lock_prot_qos_user", {arlock, arprot, arqos, aruser}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // single full-burst row
    push_ar(32'h1000_0000, 4'd15);
    start_rect(32'h1000_0000, 0, 0, 64, 1);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1");

    // two rows of 20 words with a paced sink and slow arready
    toggle = 1; ar_slow = 1;
    push_ar(32'h1000_0324, 4'd15); push_ar(32'h1000_0364, 4'd3);
    push_ar(32'h1000_0644, 4'd15); push_ar(32'h1000_0684, 4'd3);
    start_rect(32'h1000_0000, 4, 1, 80, 2);
    wait_done("t2");
    toggle = 0; ar_slow = 0;

    // 4 KB page split
    push_ar(32'h0000_0FF0, 4'd3); push_ar(32'h0000_1000, 4'd3);
    start_rect(32'h0000_0FF0, 0, 0, 32, 1);
    wait_done("t3");

    // unaligned x0 and width low bits are dropped
    push_ar(32'h0000_0644, 4'd1); push_ar(32'h0000_0964, 4'd1); push_ar(32'h0000_0C84, 4'd1);
    start_rect(32'h0000_0000, 5, 2, 9, 3);
    wait_done("t4");

    // sink stalled: FIFO fills, address phase waits for space
    stall = 1; ar_count = 0; words_in = 0; pix_out = 0; overflow = 0;
    push_ar(32'h2000_0000, 4'd15); push_ar(32'h2000_0040, 4'd15);
    push_ar(32'h2000_0080, 4'd15); push_ar(32'h2000_00C0, 4'd15);
    start_rect(32'h2000_0000, 0, 0, 256, 1);
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("t5_ar_during_stall", 64'(ar_count), 64'd2);
    check("t5_words_during_stall", 64'(words_in), 64'd32);
    check("t5_idle_bus", {arvalid, rready}, 64'd0);
    stall = 0;
    wait_done("t5");
    check("t5_ar_total", 64'(ar_count), 64'd4);
    check("t5_no_overflow", 64'(overflow), 64'd0);

    // error response on one beat, data still delivered
    beat_no = 0; err_beat = 5;
    push_ar(32'h3000_0000, 4'd15);
    start_rect(32'h3000_0000, 0, 0, 64, 1);
    wait_done("t6");
    err_beat = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_rresp_err_sticky", 64'(rresp_err), 64'd1);

    // empty rectangles: done the cycle after accept, no AR
    empty_mode = 1; ar_count = 0;
    start_rect(32'h4000_0000, 0, 0, 64, 0);
    @(negedge clk);
    check("t7_done_h0", 64'(done), 64'd1);
    check("t7_rresp_err_cleared", 64'(rresp_err), 64'd0);
    @(negedge clk);
    check("t7_done_pulse", 64'(done), 64'd0);
    start_rect(32'h4000_0000, 0, 0, 3, 2);
    @(negedge clk);
    check("t7_done_w3", 64'(done), 64'd1);
    repeat (5) @(posedge clk);
    check("t7_no_ar", 64'(ar_count), 64'd0);
    empty_mode = 0;

    // reset in the middle of a data burst
    push_ar(32'h5000_0000, 4'd15);
    start_rect(32'h5000_0000, 0, 0, 256, 1);
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rready && rvalid) begin seen = 1; break; end
    end
    check("t8_reached_data", 64'(seen), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t8_after_reset", {arvalid, rready, m_pixel_valid, busy, done}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_ar.delete(); exp_pix.delete();
    repeat (20) @(posedge clk);

    // recovery after reset
    push_ar(32'h0000_0FF0, 4'd3); push_ar(32'h0000_1000, 4'd3);
    start_rect(32'h0000_0FF0, 0, 0, 32, 1);
    wait_done("t9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
